btn_debounce_pulse: RTL and testbench

//  Front-end for the 3-bit counter: conditions two raw push-buttons (up/down).

---
 rtl/btn_db_pkg.sv | 16 +
 rtl/btn_db_channel.sv | 116 +++++++++++
 rtl/btn_debounce_pulse.sv | 78 +++++++
 tb/tb_btn_debounce_pulse.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_db_pkg.sv
// Shared types and helpers for the two-button debounce/pulse front-end.
// Pulse FSM encoding and the counter width rule used by every timer.
package btn_db_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHeld   = 2'd1,
        StRepeat = 2'd2
    } pulse_state_e;

    // One spare bit above the terminal count keeps compare logic simple.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/btn_db_channel.sv
// One button: synchroniser, stable-level debouncer and press/auto-repeat pulse FSM.
// The pulse output is combinational so the parent can register it alongside db.
module btn_db_channel
    import btn_db_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 16,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned REPEAT_CYCLES = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic db,
    output logic pulse
);

    localparam int unsigned DbW   = cnt_width(DB_CYCLES);
    localparam int unsigned TmMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TmW   = cnt_width(TmMax);

    localparam logic [DbW-1:0] DbLast   = DbW'(DB_CYCLES - 1);
    localparam logic [TmW-1:0] HoldLast = TmW'(HOLD_CYCLES - 1);
    localparam logic [TmW-1:0] RepLast  = TmW'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_s;
    logic                   db_q, db_d;
    logic [DbW-1:0]         db_cnt_q, db_cnt_d;
    logic                   rise, fall;
    pulse_state_e           state_q, state_d;
    logic [TmW-1:0]         tm_q, tm_d;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign db     = db_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_raw};
        db_d     = db_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync_s != db_q) begin
            if (db_cnt_q == DbLast) begin
                db_d = sync_s;
                rise = sync_s;
                fall = ~sync_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Pulses are raised on the accepting edge so they line up with db.
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHeld;
                    tm_d    = '0;
                    pulse   = 1'b1;
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                    tm_d    = '0;
                end else if (tm_q == HoldLast) begin
                    if (REPEAT_EN) begin
                        state_d = StRepeat;
                        tm_d    = '0;
                        pulse   = 1'b1;
                    end
                end else begin
                    tm_d = tm_q + 1'b1;
                end
            end
            StRepeat: begin
                if (fall) begin
                    state_d = StIdle;
                    tm_d    = '0;
                end else if (tm_q == RepLast) begin
                    tm_d  = '0;
                    pulse = 1'b1;
                end else begin
                    tm_d = tm_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tm_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= StIdle;
            tm_q     <= '0;
        end else begin
            sync_q   <= sync_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            tm_q     <= tm_d;
        end
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Up/down button front-end: two debounce channels and a registered arbiter that
// drops simultaneous pulse candidates and flags the conflict instead.
module btn_debounce_pulse
    import btn_db_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DB_CYCLES     = 16,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned REPEAT_CYCLES = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic up,
    output logic down,
    output logic db_up,
    output logic db_down,
    output logic conflict
);

    logic up_cand, down_cand;
    logic up_q, up_d;
    logic down_q, down_d;
    logic conflict_q, conflict_d;

    btn_db_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_EN    (REPEAT_EN),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_up (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_up_raw),
        .db     (db_up),
        .pulse  (up_cand)
    );

    btn_db_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_EN    (REPEAT_EN),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_down (
        .clk    (clk),
        .reset_n(reset_n),
        .btn_raw(btn_down_raw),
        .db     (db_down),
        .pulse  (down_cand)
    );

    always_comb begin
        up_d       = up_cand & ~down_cand;
        down_d     = down_cand & ~up_cand;
        conflict_d = up_cand & down_cand;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            up_q       <= up_d;
            down_q     <= down_d;
            conflict_q <= conflict_d;
        end
    end

    assign up       = up_q;
    assign down     = down_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Randomised scoreboard bench: stimulus pushes expected outputs from a
// window/arithmetic reference model; a monitor pops and compares every edge.
module tb_btn_debounce_pulse;

    localparam int SYNC   = 2;
    localparam int DB     = 4;
    localparam int HOLD   = 8;
    localparam int REP    = 4;
    localparam bit REP_EN = 1'b1;

    logic clk;
    logic reset_n;
    logic btn_up_raw, btn_down_raw;
    logic up, down, db_up, db_down, conflict;
    logic [4:0] outs;

    int checks;
    int failures;
    int cyc;

    logic [4:0] expq[$];
    bit         hist[2][$];
    bit         mdb[2];
    int         mpress[2];
    int         rem[2];
    bit         lvl[2];

    btn_debounce_pulse #(
        .SYNC_STAGES  (SYNC),
        .DB_CYCLES    (DB),
        .REPEAT_EN    (REP_EN),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .up          (up),
        .down        (down),
        .db_up       (db_up),
        .db_down     (db_down),
        .conflict    (conflict)
    );

    assign outs = {up, down, conflict, db_up, db_down};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [4:0] act, input logic [4:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b (up,down,conflict,db_up,db_down)",
                     name, cyc, act, exp);
        end
    endtask

    // Synchronised level seen at edge idx is the raw level sampled SYNC edges earlier.
    function automatic bit s_at(input int ch, input int idx);
        int k;
        k = idx - SYNC;
        if (k < 0) return 1'b0;
        return hist[ch][k];
    endfunction

    task automatic model_edge(output logic [4:0] e);
        int E;
        bit cand[2];
        E = hist[0].size() - 1;
        for (int ch = 0; ch < 2; ch++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (s_at(ch, E - j) == mdb[ch]) flip = 1'b0;
            end
            if (flip) begin
                mdb[ch] = ~mdb[ch];
                if (mdb[ch]) mpress[ch] = E;
            end
            cand[ch] = 1'b0;
            if (mdb[ch]) begin
                int d;
                d = E - mpress[ch];
                if (d == 0) cand[ch] = 1'b1;
                else if (REP_EN && d >= HOLD && ((d - HOLD) % REP) == 0) cand[ch] = 1'b1;
            end
        end
        e = {cand[0] & ~cand[1], cand[1] & ~cand[0], cand[0] & cand[1], mdb[0], mdb[1]};
    endtask

    task automatic cycle(input bit u, input bit d, input bit rst);
        logic [4:0] e;
        @(negedge clk);
        btn_up_raw   = u;
        btn_down_raw = d;
        if (rst) begin
            reset_n = 1'b0;
            hist[0].delete();
            hist[1].delete();
            mdb[0] = 1'b0;
            mdb[1] = 1'b0;
            expq.push_back(5'b0);
            #1 check(outs, 5'b0, "reset_async");
        end else begin
            reset_n = 1'b1;
            hist[0].push_back(u);
            hist[1].push_back(d);
            model_edge(e);
            expq.push_back(e);
        end
    endtask

    task automatic rand_run(input int n);
        bit u, d, r;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = 1'($urandom_range(0, 1));
                    rem[c] = int'($urandom_range(1, 30));
                end else begin
                    rem[c]--;
                end
            end
            u = lvl[0] ^ ($urandom_range(0, 7) == 0);
            d = lvl[1] ^ ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 399) == 0);
            cycle(u, d, r);
        end
    endtask

    // Monitor: one expected entry per active edge.
    initial begin
        logic [4:0] e;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check(outs, e, "outputs");
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        reset_n      = 1'b0;
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b1;
        mdb[0]       = 1'b0;
        mdb[1]       = 1'b0;
        mpress[0]    = 0;
        mpress[1]    = 0;
        rem[0]       = 0;
        rem[1]       = 0;
        lvl[0]       = 1'b0;
        lvl[1]       = 1'b0;

        // Reset with both held, then both presses land together.
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        repeat (30) cycle(1'b1, 1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        // Clean up press.
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        // Bouncy up press.
        for (int i = 0; i < 12; i++) cycle(((i / 2) % 2) == 0, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        // Long down hold with auto-repeat, then release.
        repeat (40) cycle(1'b0, 1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);
        // Reset while repeating with the button still held.
        repeat (20) cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b1);
        repeat (30) cycle(1'b1, 1'b0, 1'b0);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        rand_run(3000);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain cyc=%0d got=%0d want=0 pending entries", cyc, expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
